// File: rtl/microstep_executor_if.sv
// -----------------------------------------------------------------------------
// microstep_executor_if
// Bundles the sequencer handshake, memory acknowledge, ALU status and the
// datapath control word of the micro-step executor.
//   master : sequencer/datapath side (drives step_code, step_valid, mem_ack,
//            alu_zero; observes ready, strobes, zero flag and halt)
//   slave  : executor side (the reverse)
// -----------------------------------------------------------------------------
interface microstep_executor_if #(
  parameter int SM_SIG_LEN = 6,
  parameter int ALU_OP_LEN = 4
);
  logic [SM_SIG_LEN-1:0] step_code;
  logic                  step_valid;
  logic                  step_ready;
  logic                  mem_ack;
  logic                  alu_zero;
  logic                  ar_ld;
  logic                  pc_inc;
  logic                  pc_ld;
  logic                  ir_ld;
  logic                  reg_wr;
  logic                  mem_rd;
  logic                  mem_wr;
  logic [ALU_OP_LEN-1:0] alu_op;
  logic                  alu_en;
  logic                  z_out;
  logic                  halted;

  modport master (
    output step_code, step_valid, mem_ack, alu_zero,
    input  step_ready, ar_ld, pc_inc, pc_ld, ir_ld, reg_wr,
           mem_rd, mem_wr, alu_op, alu_en, z_out, halted
  );

  modport slave (
    input  step_code, step_valid, mem_ack, alu_zero,
    output step_ready, ar_ld, pc_inc, pc_ld, ir_ld, reg_wr,
           mem_rd, mem_wr, alu_op, alu_en, z_out, halted
  );
endinterface

// File: rtl/microstep_executor.sv
// -----------------------------------------------------------------------------
// microstep_executor
// Accepts micro-step codes from the sequencer over a valid/ready handshake and
// drives a registered, single-cycle datapath control word for each step.
// Memory steps hold mem_rd/mem_wr until mem_ack, then issue a one-cycle
// completion strobe. Owns the zero flag (updated only on ALU steps) and the
// halt state entered by step 57.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of microstep_executor_if (step_code/step_valid/
//           step_ready handshake, mem_ack, alu_zero, datapath strobes,
//           mem_rd/mem_wr, alu_op/alu_en, z_out, halted)
// -----------------------------------------------------------------------------
module microstep_executor #(
  parameter int SM_SIG_LEN = 6,
  parameter int ALU_OP_LEN = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  microstep_executor_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXEC     = 2'd1,
    MEM_WAIT = 2'd2,
    HALT     = 2'd3
  } state_t;

  // Full registered control word; halt is carried alongside the strobes so the
  // halted output is registered exactly like everything else.
  typedef struct packed {
    logic                  halt;
    logic                  alu_en;
    logic [ALU_OP_LEN-1:0] alu_op;
    logic                  mem_wr;
    logic                  mem_rd;
    logic                  reg_wr;
    logic                  ir_ld;
    logic                  pc_ld;
    logic                  pc_inc;
    logic                  ar_ld;
  } ctl_t;

  localparam ctl_t CTL_NONE = ctl_t'({(ALU_OP_LEN+9){1'b0}});

  // Decode one step code into the control word it produces when executed.
  function automatic ctl_t decode_step(input logic [SM_SIG_LEN-1:0] c);
    ctl_t d;
    d = CTL_NONE;
    if ((c >= 6'd36) && (c <= 6'd51)) begin
      d.alu_en = 1'b1;
      d.reg_wr = 1'b1;
      d.alu_op = ALU_OP_LEN'(c - 6'd36);
    end else begin
      case (c)
        6'd1, 6'd4, 6'd8, 6'd18, 6'd21:                d.ar_ld  = 1'b1;
        6'd2, 6'd5, 6'd9, 6'd19, 6'd22, 6'd52:         d.mem_rd = 1'b1;
        6'd10, 6'd25, 6'd28:                           d.mem_wr = 1'b1;
        6'd3: begin
          d.ir_ld  = 1'b1;
          d.pc_inc = 1'b1;
        end
        6'd6, 6'd11, 6'd13, 6'd15, 6'd17, 6'd20,
        6'd23, 6'd26, 6'd29, 6'd32, 6'd35, 6'd54:      d.pc_inc = 1'b1;
        6'd7, 6'd12, 6'd14, 6'd16, 6'd24,
        6'd27, 6'd30, 6'd31, 6'd33, 6'd34:             d.reg_wr = 1'b1;
        6'd53:                                         d.pc_ld  = 1'b1;
        6'd57:                                         d.halt   = 1'b1;
        default:                                       d = CTL_NONE;
      endcase
    end
    return d;
  endfunction

  state_t                state_r;
  state_t                state_nxt_s;
  ctl_t                  ctl_r;
  ctl_t                  ctl_nxt_s;
  ctl_t                  dec_s;
  logic                  ready_r;
  logic                  ready_nxt_s;
  logic [SM_SIG_LEN-1:0] code_r;
  logic                  z_r;

  assign dec_s = decode_step(bus.step_code);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.step_valid) begin
          if (dec_s.halt) begin
            state_nxt_s = HALT;
          end else if (dec_s.mem_rd || dec_s.mem_wr) begin
            state_nxt_s = MEM_WAIT;
          end else begin
            state_nxt_s = EXEC;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      EXEC: state_nxt_s = IDLE;
      MEM_WAIT: begin
        // The completion strobe cycle reuses EXEC, which then returns to IDLE.
        if (bus.mem_ack) begin
          state_nxt_s = EXEC;
        end else begin
          state_nxt_s = MEM_WAIT;
        end
      end
      HALT:    state_nxt_s = HALT;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output logic: control word and ready for the next cycle.
  always_comb begin
    ctl_nxt_s   = CTL_NONE;
    ready_nxt_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.step_valid) begin
          // Memory codes decode to just the request level; 57 to just halt.
          ctl_nxt_s = dec_s;
        end else begin
          ready_nxt_s = 1'b1;
        end
      end
      EXEC: ready_nxt_s = 1'b1;
      MEM_WAIT: begin
        if (bus.mem_ack) begin
          // Reads complete with a load strobe; writes complete silently.
          if (ctl_r.mem_rd) begin
            if (code_r == 6'd2) begin
              ctl_nxt_s.ir_ld = 1'b1;
            end else begin
              ctl_nxt_s.reg_wr = 1'b1;
            end
          end else begin
            ctl_nxt_s = CTL_NONE;
          end
        end else begin
          ctl_nxt_s.mem_rd = ctl_r.mem_rd;
          ctl_nxt_s.mem_wr = ctl_r.mem_wr;
        end
      end
      HALT:    ctl_nxt_s.halt = 1'b1;
      default: ctl_nxt_s = CTL_NONE;
    endcase
  end

  // Registered control word and handshake ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_r   <= CTL_NONE;
      ready_r <= 1'b1;
    end else begin
      ctl_r   <= ctl_nxt_s;
      ready_r <= ready_nxt_s;
    end
  end

  // Latch the accepted step code for the memory completion decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_r <= {SM_SIG_LEN{1'b0}};
    end else if ((state_r == IDLE) && bus.step_valid) begin
      code_r <= bus.step_code;
    end else begin
      code_r <= code_r;
    end
  end

  // Zero flag samples alu_zero during the ALU step's EXEC cycle only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_r <= 1'b0;
    end else if ((state_r == EXEC) && ctl_r.alu_en) begin
      z_r <= bus.alu_zero;
    end else begin
      z_r <= z_r;
    end
  end

  assign bus.step_ready = ready_r;
  assign bus.ar_ld      = ctl_r.ar_ld;
  assign bus.pc_inc     = ctl_r.pc_inc;
  assign bus.pc_ld      = ctl_r.pc_ld;
  assign bus.ir_ld      = ctl_r.ir_ld;
  assign bus.reg_wr     = ctl_r.reg_wr;
  assign bus.mem_rd     = ctl_r.mem_rd;
  assign bus.mem_wr     = ctl_r.mem_wr;
  assign bus.alu_op     = ctl_r.alu_op;
  assign bus.alu_en     = ctl_r.alu_en;
  assign bus.halted     = ctl_r.halt;
  assign bus.z_out      = z_r;

endmodule

// File: tb/tb_microstep_executor.sv
// -----------------------------------------------------------------------------
// tb_microstep_executor
// Directed stimulus with a scoreboard: each step pushes the expected control
// words (one per active cycle) into a queue; a negedge monitor pops and
// compares whenever any strobe or memory request is high. Handshake timing,
// zero flag, halt and reset behaviour are compared directly by the driver.
// Observation word: {ar_ld,pc_inc,pc_ld,ir_ld,reg_wr,mem_rd,mem_wr,alu_en,
//                    alu_op[3:0], step_ready}
// -----------------------------------------------------------------------------
module tb_microstep_executor;

  localparam logic [7:0] S_AR  = 8'b1000_0000;
  localparam logic [7:0] S_PCI = 8'b0100_0000;
  localparam logic [7:0] S_PCL = 8'b0010_0000;
  localparam logic [7:0] S_IR  = 8'b0001_0000;
  localparam logic [7:0] S_RW  = 8'b0000_1000;
  localparam logic [7:0] S_MRD = 8'b0000_0100;
  localparam logic [7:0] S_MWR = 8'b0000_0010;
  localparam logic [7:0] S_ALU = 8'b0000_0001;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  logic [12:0] exp_q[$];

  microstep_executor_if #(.SM_SIG_LEN(6), .ALU_OP_LEN(4)) bus ();

  microstep_executor #(.SM_SIG_LEN(6), .ALU_OP_LEN(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] ex(input logic [7:0] st, input logic [3:0] op);
    return {st, op, 1'b0};
  endfunction

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] req);
    n_checks++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for ready (bounded), present the code for one edge, return in the
  // first cycle of the step.
  task automatic send(input logic [5:0] c);
    int guard;
    guard = 0;
    while (bus.step_ready !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    chk("send_ready_wait", 16'(guard < 20), 16'd1);
    bus.step_code  = c;
    bus.step_valid = 1'b1;
    tick();
    bus.step_valid = 1'b0;
    chk("ready_low_in_step", 16'(bus.step_ready), 16'd0);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    logic [12:0] obs;
    logic [12:0] e;
    obs = {bus.ar_ld, bus.pc_inc, bus.pc_ld, bus.ir_ld, bus.reg_wr, bus.mem_rd,
           bus.mem_wr, bus.alu_en, bus.alu_op, bus.step_ready};
    if (rst_n === 1'b1 && obs[12:5] != 8'd0) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got %h, required no activity", obs);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e) begin
          n_fail++;
          $display("FAIL control_word: got %h, required %h", obs, e);
        end
      end
    end
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [5:0] code;
    logic [7:0] st;
    logic [3:0] op;
  } vec_t;

  initial begin
    vec_t vecs[7];
    logic [5:0] nops[3];
    n_checks = 0;
    n_fail   = 0;
    bus.step_code  = 6'd0;
    bus.step_valid = 1'b0;
    bus.mem_ack    = 1'b0;
    bus.alu_zero   = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    // Reset state
    chk("rst_ready",  16'(bus.step_ready), 16'd1);
    chk("rst_strobes", 16'({bus.ar_ld, bus.pc_inc, bus.pc_ld, bus.ir_ld, bus.reg_wr,
                            bus.mem_rd, bus.mem_wr, bus.alu_en, bus.alu_op}), 16'd0);
    chk("rst_z",      16'(bus.z_out), 16'd0);
    chk("rst_halted", 16'(bus.halted), 16'd0);
    #20 rst_n = 1'b1;
    tick();

    // Codes 1, 2, 3; ack two cycles after mem_rd rises
    exp_q.push_back(ex(S_AR, 4'd0));
    exp_q.push_back(ex(S_MRD, 4'd0));
    exp_q.push_back(ex(S_MRD, 4'd0));
    exp_q.push_back(ex(S_IR, 4'd0));
    exp_q.push_back(ex(S_IR | S_PCI, 4'd0));
    send(6'd1);
    tick();
    chk("ready_back_after_exec", 16'(bus.step_ready), 16'd1);
    send(6'd2);
    tick();
    chk("ready_low_mem_wait", 16'(bus.step_ready), 16'd0);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    chk("ready_low_completion", 16'(bus.step_ready), 16'd0);
    send(6'd3);

    // ALU steps and zero flag
    bus.alu_zero = 1'b1;
    exp_q.push_back(ex(S_RW | S_ALU, 4'd4));
    send(6'd40);
    chk("z_before_update", 16'(bus.z_out), 16'd0);
    tick();
    chk("z_set", 16'(bus.z_out), 16'd1);
    bus.alu_zero = 1'b0;
    exp_q.push_back(ex(S_RW | S_ALU, 4'd5));
    send(6'd41);
    chk("z_hold_in_exec", 16'(bus.z_out), 16'd1);
    tick();
    chk("z_clear", 16'(bus.z_out), 16'd0);

    // Write with ack on the first MEM_WAIT cycle
    exp_q.push_back(ex(S_MWR, 4'd0));
    send(6'd10);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    chk("wr_ready_low_cmpl", 16'(bus.step_ready), 16'd0);
    tick();
    chk("wr_ready_back", 16'(bus.step_ready), 16'd1);

    // mem_ack while idle is ignored
    bus.mem_ack = 1'b1;
    tick();
    tick();
    bus.mem_ack = 1'b0;
    chk("idle_ack_ignored", 16'(bus.step_ready), 16'd1);

    // Read other than code 2 completes with reg_wr
    exp_q.push_back(ex(S_MRD, 4'd0));
    exp_q.push_back(ex(S_RW, 4'd0));
    send(6'd52);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;

    // Non-memory decode table (alu_zero=0 keeps z at 0)
    vecs[0] = '{6'd4,  S_AR,          4'd0};
    vecs[1] = '{6'd6,  S_PCI,         4'd0};
    vecs[2] = '{6'd7,  S_RW,          4'd0};
    vecs[3] = '{6'd53, S_PCL,         4'd0};
    vecs[4] = '{6'd54, S_PCI,         4'd0};
    vecs[5] = '{6'd51, S_RW | S_ALU,  4'd15};
    vecs[6] = '{6'd36, S_RW | S_ALU,  4'd0};
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(ex(vecs[i].st, vecs[i].op));
      send(vecs[i].code);
    end
    tick();

    // NOP codes: one EXEC cycle, no strobes, z unchanged
    bus.alu_zero = 1'b1;
    nops[0] = 6'd0;
    nops[1] = 6'd56;
    nops[2] = 6'd62;
    for (int i = 0; i < 3; i++) begin
      send(nops[i]);
      tick();
      chk("nop_ready_back", 16'(bus.step_ready), 16'd1);
    end
    chk("nop_z_unchanged", 16'(bus.z_out), 16'd0);
    chk("queue_drained_mid", 16'(exp_q.size()), 16'd0);

    // Halt, then a held-valid code 1 must be ignored
    send(6'd57);
    chk("halted_set", 16'(bus.halted), 16'd1);
    bus.step_code  = 6'd1;
    bus.step_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("halt_ready_low", 16'(bus.step_ready), 16'd0);
      chk("halt_stays", 16'(bus.halted), 16'd1);
    end
    rst_n = 1'b0;
    #1;
    chk("halt_rst_halted", 16'(bus.halted), 16'd0);
    chk("halt_rst_ready", 16'(bus.step_ready), 16'd1);
    bus.step_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Reset in the middle of a read
    exp_q.push_back(ex(S_MRD, 4'd0));
    send(6'd5);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrd_rst_memrd", 16'(bus.mem_rd), 16'd0);
    chk("midrd_rst_ready", 16'(bus.step_ready), 16'd1);
    #1 rst_n = 1'b1;
    bus.mem_ack = 1'b1;
    tick();
    tick();
    bus.mem_ack = 1'b0;
    tick();
    chk("midrd_idle_after", 16'(bus.step_ready), 16'd1);

    chk("queue_drained_end", 16'(exp_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
